// File: rtl/router_ctrl.sv
// rtl/router_ctrl.sv - packet router control FSM with per-port read timeout flush
// Steers header-addressed packets into one of three output FIFOs.
module router_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [2:0] write_enb,
    output logic [2:0] valid_out,
    output logic [2:0] soft_reset,
    output logic       fifo_full_sel
);

    typedef enum logic [2:0] {
        ST_DA, ST_LFD, ST_LD, ST_FFS, ST_LAF, ST_LP, ST_CPE, ST_WTE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [2:0][4:0]  cnt_q, cnt_d;
    logic [2:0]       soft_reset_q, soft_reset_d;

    // Port 3 does not exist; selecting it yields 0.
    function automatic logic pick(input logic [2:0] vec, input logic [1:0] idx);
        case (idx)
            2'd0:    pick = vec[0];
            2'd1:    pick = vec[1];
            2'd2:    pick = vec[2];
            default: pick = 1'b0;
        endcase
    endfunction

    assign fifo_full_sel = pick(fifo_full, addr_q);
    assign valid_out     = ~fifo_empty;
    assign soft_reset    = soft_reset_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_DA: begin
                if (pkt_valid && data_in != 2'd3) begin
                    addr_d  = data_in;
                    state_d = pick(fifo_empty, data_in) ? ST_LFD : ST_WTE;
                end
            end
            ST_LFD:  state_d = ST_LD;
            ST_LD: begin
                if (fifo_full_sel)   state_d = ST_FFS;
                else if (!pkt_valid) state_d = ST_LP;
            end
            ST_FFS:  if (!fifo_full_sel) state_d = ST_LAF;
            ST_LAF: begin
                if (parity_done)        state_d = ST_DA;
                else if (low_pkt_valid) state_d = ST_LP;
                else                    state_d = ST_LD;
            end
            ST_LP:   state_d = ST_CPE;
            ST_CPE:  state_d = fifo_full_sel ? ST_FFS : ST_DA;
            ST_WTE:  if (pick(fifo_empty, addr_q)) state_d = ST_LFD;
            default: state_d = ST_DA;
        endcase
        // A timeout flush of the active port abandons the packet.
        if (pick(soft_reset_q, addr_q) && state_q != ST_DA) state_d = ST_DA;
    end

    always_comb begin
        cnt_d        = cnt_q;
        soft_reset_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (read_enb[i] || !valid_out[i]) begin
                cnt_d[i] = 5'd0;
            end else if (cnt_q[i] == 5'd29) begin
                cnt_d[i]        = 5'd0;
                soft_reset_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_DA;
            addr_q       <= 2'd0;
            cnt_q        <= '0;
            soft_reset_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign detect_add    = (state_q == ST_DA);
    assign lfd_state     = (state_q == ST_LFD);
    assign ld_state      = (state_q == ST_LD);
    assign laf_state     = (state_q == ST_LAF);
    assign full_state    = (state_q == ST_FFS);
    assign rst_int_reg   = (state_q == ST_CPE);
    assign write_enb_reg = (state_q == ST_LD) || (state_q == ST_LP) || (state_q == ST_LAF);
    assign busy          = !((state_q == ST_DA) || (state_q == ST_LD));
    assign write_enb     = write_enb_reg ? (3'b001 << addr_q) : 3'b000;

endmodule
